// File: rtl/stream_mux_2to1_rr.sv
// rtl/stream_mux_2to1_rr.sv - two-input round-robin packet merger with registered output
module stream_mux_2to1_rr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in0_data,
  input  logic         in0_last,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_served;
  logic   last_served_next;
  logic   load;
  logic   grant0;
  logic   grant1;
  logic   xfer0;
  logic   xfer1;

  // The output slot can take a new beat when empty or when it drains this cycle
  assign load  = !out_valid || out_ready;
  assign xfer0 = in0_valid && in0_ready;
  assign xfer1 = in1_valid && in1_ready;

  // Arbitration and input readies: round-robin in IDLE, fixed owner while locked
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state)
      IDLE: begin
        grant0    = in0_valid && (!in1_valid || last_served);
        grant1    = in1_valid && (!in0_valid || !last_served);
        in0_ready = grant0 && load;
        in1_ready = grant1 && load;
      end
      LOCK0:   in0_ready = load;
      LOCK1:   in1_ready = load;
      default: ;
    endcase
  end

  // Next-state: single-beat packets stay in IDLE, longer packets lock until last
  always_comb begin
    state_next       = state;
    last_served_next = last_served;
    case (state)
      IDLE: begin
        if (xfer0) begin
          if (in0_last) last_served_next = 1'b0;
          else          state_next       = LOCK0;
        end else if (xfer1) begin
          if (in1_last) last_served_next = 1'b1;
          else          state_next       = LOCK1;
        end
      end
      LOCK0: begin
        if (xfer0 && in0_last) begin
          state_next       = IDLE;
          last_served_next = 1'b0;
        end
      end
      LOCK1: begin
        if (xfer1 && in1_last) begin
          state_next       = IDLE;
          last_served_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset favours channel 0 on the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_next;
      last_served <= last_served_next;
    end
  end

  // Output register: capture the accepted beat, drop valid once drained, hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else if (xfer0 || xfer1) begin
      out_valid <= 1'b1;
      out_data  <= xfer1 ? in1_data : in0_data;
      out_last  <= xfer1 ? in1_last : in0_last;
      out_sel   <= xfer1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
